fitness_evaluation_fsm: RTL and testbench

FITNESS_EVALUATION_FSM -- requirements
Module: fitness_evaluation_fsm

---
 rtl/fitness_pkg.sv | 20 ++
 rtl/error_accumulator.sv | 87 ++++++++
 rtl/fitness_evaluation_fsm.sv | 167 ++++++++++++++++
 tb/tb_fitness_evaluation_fsm.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fitness_pkg.sv
// Shared state codes and default parameter values for the fitness evaluation block.
package fitness_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PROCESSING = 3'd1,
        ST_DONE       = 3'd2,
        ST_STALLED    = 3'd3,
        ST_INPUT_WAIT = 3'd4,
        ST_ZEROING    = 3'd5
    } fsm_state_e;

    localparam int DEF_N_VECTORS     = 16;
    localparam int DEF_IN_W          = 8;
    localparam int DEF_OUT_W         = 8;
    localparam int DEF_SUM_W         = 32;
    localparam int DEF_IGNORE_CYCLES = 5;
    localparam int DWELL_W           = 16;

endpackage

// File: rtl/error_accumulator.sv
// Masked per-bit compare of the phenotype output against the golden vector,
// with saturating per-bit error sums, a saturating total and an abort-threshold test.
module error_accumulator
    import fitness_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W,
    parameter int SUM_W = DEF_SUM_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [OUT_W-1:0]       chrom_output,
    input  logic [OUT_W-1:0]       expected,
    input  logic [OUT_W-1:0]       valid_mask,
    input  logic [SUM_W-1:0]       threshold,
    output logic [OUT_W*SUM_W-1:0] error_sums,
    output logic [SUM_W-1:0]       total_error,
    output logic                   over_threshold
);

    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                 input logic [SUM_W-1:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
    endfunction

    function automatic logic [SUM_W-1:0] popcount(input logic [OUT_W-1:0] v);
        logic [SUM_W-1:0] n;
        n = '0;
        for (int i = 0; i < OUT_W; i++) begin
            n = n + {{(SUM_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    logic [OUT_W-1:0] err_bits;
    logic [SUM_W-1:0] sum_q [OUT_W];
    logic [SUM_W-1:0] sum_d [OUT_W];
    logic [SUM_W-1:0] total_q;
    logic [SUM_W-1:0] total_d;
    logic [SUM_W-1:0] total_upd;

    assign err_bits       = (chrom_output ^ expected) & valid_mask;
    assign total_upd      = sat_add(total_q, popcount(err_bits));
    // The abort decision looks at the total as it will be after this cycle's errors.
    assign over_threshold = (threshold != '0) && (total_upd > threshold);

    always_comb begin
        total_d = total_q;
        for (int b = 0; b < OUT_W; b++) begin
            sum_d[b] = sum_q[b];
            if (clear) begin
                sum_d[b] = '0;
            end else if (enable && err_bits[b]) begin
                sum_d[b] = sat_add(sum_q[b], SUM_W'(1));
            end
        end
        if (clear) begin
            total_d = '0;
        end else if (enable) begin
            total_d = total_upd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            total_q <= '0;
            for (int b = 0; b < OUT_W; b++) begin
                sum_q[b] <= '0;
            end
        end else begin
            total_q <= total_d;
            for (int b = 0; b < OUT_W; b++) begin
                sum_q[b] <= sum_d[b];
            end
        end
    end

    for (genvar g = 0; g < OUT_W; g++) begin : g_pack
        assign error_sums[g*SUM_W +: SUM_W] = sum_q[g];
    end

    assign total_error = total_q;

endmodule

// File: rtl/fitness_evaluation_fsm.sv
// Sequences test vectors into an evolved phenotype, scores its outputs against golden
// vectors after a settle window, and reports per-bit and total error counts.
module fitness_evaluation_fsm
    import fitness_pkg::*;
#(
    parameter int N_VECTORS     = DEF_N_VECTORS,
    parameter int IN_W          = DEF_IN_W,
    parameter int OUT_W         = DEF_OUT_W,
    parameter int SUM_W         = DEF_SUM_W,
    parameter int IGNORE_CYCLES = DEF_IGNORE_CYCLES,
    localparam int IDX_W        = (N_VECTORS > 1) ? $clog2(N_VECTORS) : 1
) (
    input  logic                       iClock,
    input  logic                       iReset_n,
    input  logic                       iStart,
    input  logic                       iDoneAck,
    input  logic                       iStall,
    input  logic [DWELL_W-1:0]         iDwellCycles,
    input  logic [SUM_W-1:0]           iAbortThreshold,
    input  logic [N_VECTORS*IN_W-1:0]  iInputSequence,
    input  logic [N_VECTORS*OUT_W-1:0] iExpectedOutput,
    input  logic [N_VECTORS*OUT_W-1:0] iValidMask,
    input  logic [OUT_W-1:0]           iChromOutput,
    output logic [IN_W-1:0]            oChromInput,
    output logic                       oZeroCircuit,
    output logic                       oReady,
    output logic                       oDone,
    output logic                       oAborted,
    output logic [OUT_W*SUM_W-1:0]     oErrorSums,
    output logic [SUM_W-1:0]           oTotalError,
    output logic [IDX_W-1:0]           oVectorIndex,
    output logic [2:0]                 oState
);

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N_VECTORS - 1);
    localparam logic [DWELL_W-1:0] IGNORE_CNT = DWELL_W'(IGNORE_CYCLES);
    localparam logic [DWELL_W-1:0] MIN_DWELL  = DWELL_W'(IGNORE_CYCLES + 1);

    fsm_state_e         state_q, state_d;
    fsm_state_e         end_state;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [DWELL_W-1:0] count_q, count_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               aborted_q, aborted_d;
    logic [IN_W-1:0]    chrom_in_q, chrom_in_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               zero_q, zero_d;
    logic               acc_clear, acc_enable, acc_over;
    logic [OUT_W-1:0]   cur_expected, cur_valid;

    assign cur_expected = iExpectedOutput[int'(index_q)*OUT_W +: OUT_W];
    assign cur_valid    = iValidMask[int'(index_q)*OUT_W +: OUT_W];
    assign end_state    = iStall ? ST_STALLED : ST_DONE;

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        count_d    = count_q;
        dwell_d    = dwell_q;
        aborted_d  = aborted_q;
        acc_clear  = 1'b0;
        acc_enable = 1'b0;
        chrom_in_d = iInputSequence[int'(index_q)*IN_W +: IN_W];
        unique case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    acc_clear = 1'b1;
                    aborted_d = 1'b0;
                    index_d   = '0;
                    count_d   = '0;
                    // A dwell shorter than the settle window would never score anything.
                    dwell_d   = (iDwellCycles > IGNORE_CNT) ? iDwellCycles : MIN_DWELL;
                    state_d   = ST_ZEROING;
                end
            end
            ST_ZEROING: begin
                state_d = ST_INPUT_WAIT;
            end
            ST_INPUT_WAIT: begin
                count_d = '0;
                state_d = ST_PROCESSING;
            end
            ST_PROCESSING: begin
                acc_enable = (count_q >= IGNORE_CNT);
                count_d    = count_q + DWELL_W'(1);
                if (acc_enable && acc_over) begin
                    aborted_d = 1'b1;
                    state_d   = end_state;
                end else if (count_q == dwell_q - DWELL_W'(1)) begin
                    if (index_q != LAST_IDX) begin
                        index_d = index_q + IDX_W'(1);
                        state_d = ST_INPUT_WAIT;
                    end else begin
                        state_d = end_state;
                    end
                end
            end
            ST_STALLED: begin
                if (!iStall) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (iDoneAck) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE);
        zero_d  = (state_d == ST_ZEROING);
    end

    always_ff @(posedge iClock) begin
        if (!iReset_n) begin
            state_q    <= ST_IDLE;
            index_q    <= '0;
            count_q    <= '0;
            dwell_q    <= MIN_DWELL;
            aborted_q  <= 1'b0;
            chrom_in_q <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            count_q    <= count_d;
            dwell_q    <= dwell_d;
            aborted_q  <= aborted_d;
            chrom_in_q <= chrom_in_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            zero_q     <= zero_d;
        end
    end

    error_accumulator #(
        .OUT_W(OUT_W),
        .SUM_W(SUM_W)
    ) u_error_accumulator (
        .clk           (iClock),
        .rst_n         (iReset_n),
        .clear         (acc_clear),
        .enable        (acc_enable),
        .chrom_output  (iChromOutput),
        .expected      (cur_expected),
        .valid_mask    (cur_valid),
        .threshold     (iAbortThreshold),
        .error_sums    (oErrorSums),
        .total_error   (oTotalError),
        .over_threshold(acc_over)
    );

    assign oChromInput  = chrom_in_q;
    assign oZeroCircuit = zero_q;
    assign oReady       = ready_q;
    assign oDone        = done_q;
    assign oAborted     = aborted_q;
    assign oVectorIndex = index_q;
    assign oState       = state_q;

endmodule

// File: tb/tb_fitness_evaluation_fsm.sv
// Bench for fitness_evaluation_fsm: a run-timeline model checked every cycle, plus literal checks.
`timescale 1ns/1ps
module tb_fitness_evaluation_fsm;
    localparam int N   = 16;
    localparam int IW  = 8;
    localparam int OW  = 8;
    localparam int SW  = 32;
    localparam int IGN = 5;
    localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, ack, stall;
    logic [15:0]   dwell;
    logic [SW-1:0] thr;
    logic [N*IW-1:0] seq_v;
    logic [N*OW-1:0] exp_v, val_v;
    logic [OW-1:0] chrom_out;
    logic [IW-1:0] chrom_in;
    logic          zero, ready, done, aborted;
    logic [OW*SW-1:0] sums;
    logic [SW-1:0] total;
    logic [3:0]    idx;
    logic [2:0]    state;

    logic [7:0] seq_a [N];
    logic [7:0] exp_a [N];
    logic [7:0] val_a [N];
    int mode;

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < N; g++) begin : g_vec
        assign seq_v[g*IW +: IW] = seq_a[g];
        assign exp_v[g*OW +: OW] = exp_a[g];
        assign val_v[g*OW +: OW] = val_a[g];
    end

    // Phenotype stand-in: answers the current vector correctly, with bit 3 flipped, or fully inverted.
    always_comb begin
        chrom_out = exp_a[idx];
        if (mode == 1) chrom_out = exp_a[idx] ^ 8'h08;
        else if (mode == 2) chrom_out = ~exp_a[idx];
    end

    fitness_evaluation_fsm dut (
        .iClock         (clk),
        .iReset_n       (rst_n),
        .iStart         (start),
        .iDoneAck       (ack),
        .iStall         (stall),
        .iDwellCycles   (dwell),
        .iAbortThreshold(thr),
        .iInputSequence (seq_v),
        .iExpectedOutput(exp_v),
        .iValidMask     (val_v),
        .iChromOutput   (chrom_out),
        .oChromInput    (chrom_in),
        .oZeroCircuit   (zero),
        .oReady         (ready),
        .oDone          (done),
        .oAborted       (aborted),
        .oErrorSums     (sums),
        .oTotalError    (total),
        .oVectorIndex   (idx),
        .oState         (state)
    );

    // Inputs as seen at each active edge
    logic          s_rst, s_start, s_ack, s_stall;
    logic [15:0]   s_dwell;
    logic [SW-1:0] s_thr;
    logic [OW-1:0] s_chrom;
    always @(posedge clk) begin
        s_rst   <= rst_n;
        s_start <= start;
        s_ack   <= ack;
        s_stall <= stall;
        s_dwell <= dwell;
        s_thr   <= thr;
        s_chrom <= chrom_out;
    end

    // Model: a run is a timeline of elapsed edges since start; position on it gives state and vector.
    int       m_state, m_idx, m_e, m_dwell;
    longint   m_sum [OW];
    longint   m_total;
    bit       m_abort, m_run, m_init;
    logic [7:0] m_chrom;

    task automatic model_clear();
        for (int b = 0; b < OW; b++) m_sum[b] = 0;
        m_total = 0;
        m_abort = 0;
    endtask

    task automatic model_step();
        logic [7:0] nxt_chrom;
        logic [7:0] err;
        int v, o;
        bit fin;
        if (s_rst === 1'b0) begin
            m_state = 0; m_idx = 0; m_run = 0; m_e = 0; m_chrom = 8'h00;
            model_clear();
            return;
        end
        nxt_chrom = seq_a[m_idx];
        fin = 0;
        if (m_run) begin
            if (m_e >= 2) begin
                v = (m_e - 2) / (m_dwell + 1);
                o = (m_e - 2) % (m_dwell + 1);
                if (o >= 1 && (o - 1) >= IGN) begin
                    err = (s_chrom ^ exp_a[v]) & val_a[v];
                    for (int b = 0; b < OW; b++)
                        if (err[b]) m_sum[b] = (m_sum[b] >= MAXV) ? MAXV : m_sum[b] + 1;
                    m_total = m_total + $countones(err);
                    if (m_total > MAXV) m_total = MAXV;
                    if (s_thr != 0 && m_total > longint'(s_thr)) begin
                        m_abort = 1;
                        fin = 1;
                    end
                end
            end
            m_e++;
            if (!fin) begin
                v = (m_e - 2) / (m_dwell + 1);
                o = (m_e - 2) % (m_dwell + 1);
                if (v >= N) fin = 1;
                else begin
                    m_idx = v;
                    m_state = (o == 0) ? 4 : 1;
                end
            end
            if (fin) begin
                m_run = 0;
                m_state = s_stall ? 3 : 2;
            end
        end else begin
            if (m_state == 0 && s_start) begin
                model_clear();
                m_dwell = (int'(s_dwell) > IGN) ? int'(s_dwell) : IGN + 1;
                m_idx = 0; m_e = 1; m_run = 1; m_state = 5;
            end else if (m_state == 3 && !s_stall) begin
                m_state = 2;
            end else if (m_state == 2 && s_ack) begin
                m_state = 0;
            end
        end
        m_chrom = nxt_chrom;
    endtask

    task automatic compare_outputs();
        logic [OW*SW-1:0] e_sums;
        logic [OW*SW+51:0] act, req;
        for (int b = 0; b < OW; b++) e_sums[b*SW +: SW] = m_sum[b][SW-1:0];
        act = {state, ready, done, zero, aborted, idx, chrom_in, total, sums};
        req = {3'(m_state), (m_state == 0), (m_state == 2), (m_state == 5), m_abort,
               4'(m_idx), m_chrom, m_total[SW-1:0], e_sums};
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL cycle_check t=%0t actual st=%0d rdy/done/zero=%b%b%b ab=%b idx=%0d ci=%h tot=%0d sums=%h required st=%0d ab=%b idx=%0d ci=%h tot=%0d sums=%h",
                     $time, state, ready, done, zero, aborted, idx, chrom_in, total, sums,
                     m_state, m_abort, m_idx, m_chrom, m_total, e_sums);
        end
    endtask

    initial begin
        m_init = 0;
        forever begin
            @(negedge clk);
            if (s_rst === 1'b0) m_init = 1;
            if (m_init) begin
                model_step();
                compare_outputs();
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic longint sum_of(input int b);
        return longint'(sums[b*SW +: SW]);
    endfunction

    task automatic start_run(input int d, input logic [SW-1:0] t, input int md);
        @(negedge clk);
        dwell = 16'(d); thr = t; mode = md; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Edges from the start edge until DONE or STALLED is first visible.
    task automatic wait_end(output int cyc);
        bit hit;
        cyc = 1;
        hit = 0;
        while (!hit && cyc <= 5000) begin
            @(negedge clk);
            if (done || state == 3'd3) hit = 1;
            else cyc++;
        end
        if (!hit) begin
            n_checks++; n_fail++;
            $display("FAIL wait_end timeout actual=%0d cycles required=end of run", cyc);
        end
    endtask

    task automatic do_ack();
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;
    endtask

    initial begin
        int lat, n;
        rst_n = 1'b0; start = 1'b0; ack = 1'b0; stall = 1'b0;
        dwell = 16'd100; thr = '0; mode = 0;
        for (int v = 0; v < N; v++) begin
            seq_a[v] = 8'(v * 17 + 3);
            exp_a[v] = 8'(v * 29) ^ 8'h5A;
            val_a[v] = 8'hFF;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", ready, 1);
        chk("reset_done", done, 0);
        chk("reset_zero", zero, 0);
        chk("reset_state", state, 0);
        chk("reset_total", total, 0);

        // Perfect match
        start_run(100, '0, 0);
        wait_end(lat);
        chk("perfect_latency", lat, 1617);
        chk("perfect_total", total, 0);
        chk("perfect_sum3", sum_of(3), 0);
        do_ack();
        chk("perfect_idle", state, 0);

        // Bit 3 always wrong
        start_run(100, '0, 1);
        wait_end(lat);
        chk("bit3_sum3", sum_of(3), 1520);
        chk("bit3_sum0", sum_of(0), 0);
        chk("bit3_total", total, 1520);
        chk("bit3_index", idx, 15);
        do_ack();

        // Bit 3 masked out
        for (int v = 0; v < N; v++) val_a[v] = 8'hF7;
        start_run(100, '0, 1);
        wait_end(lat);
        chk("mask_sum3", sum_of(3), 0);
        chk("mask_total", total, 0);
        do_ack();
        for (int v = 0; v < N; v++) val_a[v] = 8'hFF;

        // Early abort
        start_run(100, 32'd10, 2);
        wait_end(lat);
        chk("abort_latency", lat, 9);
        chk("abort_flag", aborted, 1);
        chk("abort_total", total, 16);
        chk("abort_index", idx, 0);
        chk("abort_sum0", sum_of(0), 2);
        do_ack();
        chk("abort_kept_idle", aborted, 1);
        thr = '0;

        // Stall and acknowledge, dwell 6
        stall = 1'b1;
        start_run(6, '0, 1);
        wait_end(lat);
        chk("stall_latency", lat, 113);
        n = 0;
        while (state == 3'd3 && n < 100) begin
            n++;
            if (n == 20) stall = 1'b0;
            @(negedge clk);
        end
        chk("stall_cycles", n, 20);
        chk("stall_then_done", done, 1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("start_ignored_in_done", state, 2);
        do_ack();
        chk("ack_to_idle", state, 0);
        chk("kept_total", total, 16);
        chk("kept_sum3", sum_of(3), 16);

        // Dwell clamped from 2 up to 6
        start_run(2, '0, 2);
        wait_end(lat);
        chk("clamp_latency", lat, 113);
        chk("clamp_sum0", sum_of(0), 16);
        chk("clamp_total", total, 128);
        do_ack();

        // Mid-run reset at vector 7; acknowledge during processing must be ignored
        start_run(2, '0, 2);
        do_ack();
        chk("ack_ignored_running", ready, 0);
        n = 0;
        while (idx != 4'd7 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reached_vector7", idx, 7);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_state", state, 0);
        chk("midreset_index", idx, 0);
        chk("midreset_total", total, 0);
        chk("midreset_sum0", sum_of(0), 0);
        chk("midreset_chrom", chrom_in, 0);
        chk("midreset_ready", ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", ready, 1);
        chk("post_reset_zero", zero, 0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_checks++; n_fail++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
